trig_deg_lut: RTL and testbench
===============================

// Module: trig_deg_lut
// PURPOSE
// - Registered sine/cosine generator for an integer angle in degrees, scaled to a fixed amplitude.
// - Feeds the hybrid-control jump-set evaluation, which needs sin/cos of (theta+phi) and (theta-phi).
// - Each angle pair uses one instance.
// - Pure lookup: one quarter-wave table plus quadrant folding. No CORDIC, no multipliers.
// PARAMETERS
// - AMP    1000   output value representing 1.0 (sin 90 = +AMP)
// - ANG_W  32     width of the signed degree input
// PORTS
// - i_clock  in   1           single clock; all state updates on posedge
// - i_RESET  in   1           asynchronous, active-low reset
// - i_theta  in   32 signed   angle in integer degrees, full signed range accepted
// - o_cos    out  32 signed   round(AMP*cos(i_theta deg)), two's complement
// - o_sin    out  32 signed   round(AMP*sin(i_theta deg)), two's complement
// BEHAVIOUR
// - Reset: all pipeline registers clear to the angle-0 state.
//   - o_cos = +1000, o_sin = 0, asserted asynchronously while i_RESET = 0.
//   - Reset mid-stream discards in-flight angles.
// - Latency: exactly 2 clocks, fully pipelined, one new angle accepted per clock, no handshake.
// - Stage 1 (normalise): a = i_theta mod 360, mapped into 0..359.
//   - Negative inputs: a = ((i_theta % 360) + 360) % 360, e.g. -30 -> 330, -360 -> 0.
//   - Exact for every 32-bit value, including -2147483648 -> 232.
//   - Registered as a 9-bit unsigned value.
// - Stage 2 (fold + lookup): q = quadrant, r = offset 0..89 within the quadrant. T[k] = round(AMP*sin(k deg)), k = 0..90.
//   - 0..89:    sin =  T[r],     cos =  T[90-r]
//   - 90..179:  sin =  T[90-r],  cos = -T[r]
//   - 180..269: sin = -T[r],     cos = -T[90-r]
//   - 270..359: sin = -T[90-r],  cos =  T[r]
//   - Results are sign-extended to 32 bits and registered into o_sin/o_cos.
// - Table rounding: round half away from zero.
//   - T[0]=0, T[1]=17, T[30]=500, T[45]=707, T[52]=788, T[60]=866, T[89]=1000, T[90]=1000.
// - Symmetry guarantees:
//   - Output magnitude never exceeds AMP.
//   - Exact values at 0/90/180/270: one output is exactly 0, the other exactly ±AMP.
//   - A negative zero is never produced; -T[0] gives 0.
// - Output range is ±1000, so downstream products of a 32-bit operand below ~2.1e6 cannot overflow 32 bits.
// STRUCTURE
// - Shared package trig_pkg holds:
//   - localparam AMP = 1000
//   - localparam DEG_FULL = 360
//   - 91-entry constant table SIN_Q[0:90] as 11-bit unsigned values
// - Sub-module sin_quarter_lut: combinational, index 0..90 in, T[index] out. Two instances per block, one for sin and one for cos.
// - Modulo: use a constant-divisor reduction (multiply-by-reciprocal or staged subtraction). No generic divider.
// TESTING
// - Reset: hold i_RESET=0 with i_theta=77 -> o_cos=1000, o_sin=0. Release, then two clocks later -> o_cos=225, o_sin=974.
// - Cardinal angles 0/90/180/270 -> (cos,sin) = (1000,0) / (0,1000) / (-1000,0) / (0,-1000).
// - Octant points: 30 -> (866,500); -30 -> (866,-500); 405 -> (707,707); 135 -> (-707,707).
// - Extremes: -2147483648 -> (-616,-788); 2147483647 (=127 deg) -> (-602,799); 359 -> (1000,-17).
// - Streaming: new angle every clock for 0..719 and -720..-1.
//   - Each output pair matches the reference model for the input two cycles earlier.
//   - sin²+cos² lies within AMP² ± 2*AMP.
// - Reset asserted mid-stream for one cycle: outputs go immediately to (1000,0). The first valid result appears 2 clocks after release.

Source files
------------

// File: rtl/trig_deg_lut_pkg.sv
// Shared constants, quarter-wave sine table and the degree-normalisation helper
// for the registered sin/cos lookup.
package trig_pkg;

  localparam int          AMP            = 1000;
  localparam int          DEG_FULL       = 360;
  localparam int          QTR            = 90;
  localparam int          ANG_W          = 32;
  localparam int unsigned MOD_STAGES     = 24;
  localparam int unsigned HALF_RANGE_MOD = 128;  // 2**31 mod 360

  typedef enum logic [1:0] {
    QUAD_0,
    QUAD_1,
    QUAD_2,
    QUAD_3
  } quad_e;

  localparam logic [10:0] SIN_Q [0:90] = '{
    11'd0,   11'd17,  11'd35,  11'd52,  11'd70,  11'd87,  11'd105, 11'd122, 11'd139, 11'd156,
    11'd174, 11'd191, 11'd208, 11'd225, 11'd242, 11'd259, 11'd276, 11'd292, 11'd309, 11'd326,
    11'd342, 11'd358, 11'd375, 11'd391, 11'd407, 11'd423, 11'd438, 11'd454, 11'd469, 11'd485,
    11'd500, 11'd515, 11'd530, 11'd545, 11'd559, 11'd574, 11'd588, 11'd602, 11'd616, 11'd629,
    11'd643, 11'd656, 11'd669, 11'd682, 11'd695, 11'd707, 11'd719, 11'd731, 11'd743, 11'd755,
    11'd766, 11'd777, 11'd788, 11'd799, 11'd809, 11'd819, 11'd829, 11'd839, 11'd848, 11'd857,
    11'd866, 11'd875, 11'd883, 11'd891, 11'd899, 11'd906, 11'd914, 11'd921, 11'd927, 11'd934,
    11'd940, 11'd946, 11'd951, 11'd956, 11'd961, 11'd966, 11'd970, 11'd974, 11'd978, 11'd982,
    11'd985, 11'd988, 11'd990, 11'd993, 11'd995, 11'd996, 11'd998, 11'd999, 11'd999, 11'd1000,
    11'd1000
  };

  // Offset-binary view makes the input unsigned; the 2**31 bias is removed after reduction.
  function automatic logic [8:0] deg_mod360(input logic signed [ANG_W-1:0] theta);
    logic [ANG_W-1:0] rem;
    logic [ANG_W-1:0] sub;
    logic [ANG_W-1:0] fix;
    rem = {~theta[ANG_W-1], theta[ANG_W-2:0]};
    for (int unsigned i = MOD_STAGES; i > 0; i--) begin
      sub = ANG_W'(DEG_FULL) << (i - 1);
      if (rem >= sub) rem = rem - sub;
    end
    fix = rem + ANG_W'(DEG_FULL - HALF_RANGE_MOD);
    if (fix >= ANG_W'(DEG_FULL)) fix = fix - ANG_W'(DEG_FULL);
    return 9'(fix);
  endfunction

endpackage

// File: rtl/trig_deg_lut_if.sv
// Angle-in / sin-cos-out bundle for one trig_deg_lut instance.
interface trig_deg_lut_if;
  import trig_pkg::*;

  logic signed [ANG_W-1:0] i_theta;
  logic signed [ANG_W-1:0] o_cos;
  logic signed [ANG_W-1:0] o_sin;

  modport master (output i_theta, input o_cos, input o_sin);
  modport slave  (input i_theta, output o_cos, output o_sin);

endinterface

// File: rtl/trig_deg_lut_sin_quarter_lut.sv
// Combinational quarter-wave lookup: index 0..90 -> round(AMP*sin(index deg)).
module sin_quarter_lut
  import trig_pkg::*;
(
  input  logic [6:0]  i_idx,
  output logic [10:0] o_val
);

  always_comb begin
    o_val = '0;
    if (i_idx <= 7'(QTR)) o_val = SIN_Q[i_idx];
  end

endmodule

// File: rtl/trig_deg_lut.sv
// Two-stage registered sin/cos of an integer degree angle: normalise to 0..359,
// then quadrant-fold into two quarter-wave lookups.
module trig_deg_lut
  import trig_pkg::*;
(
  input  logic           i_clock,
  input  logic           i_RESET,
  trig_deg_lut_if.slave  io_bus
);

  logic [8:0]              r_ang;
  logic signed [ANG_W-1:0] r_cos;
  logic signed [ANG_W-1:0] r_sin;

  quad_e                   w_quad;
  logic [6:0]              w_off;
  logic [6:0]              w_sin_idx;
  logic [6:0]              w_cos_idx;
  logic                    w_sin_neg;
  logic                    w_cos_neg;
  logic [10:0]             w_sin_mag;
  logic [10:0]             w_cos_mag;
  logic signed [ANG_W-1:0] w_sin_ext;
  logic signed [ANG_W-1:0] w_cos_ext;
  logic signed [ANG_W-1:0] w_sin_res;
  logic signed [ANG_W-1:0] w_cos_res;

  always_comb begin
    w_quad = QUAD_0;
    w_off  = r_ang[6:0];
    if (r_ang >= 9'd270) begin
      w_quad = QUAD_3;
      w_off  = 7'(r_ang - 9'd270);
    end else if (r_ang >= 9'd180) begin
      w_quad = QUAD_2;
      w_off  = 7'(r_ang - 9'd180);
    end else if (r_ang >= 9'd90) begin
      w_quad = QUAD_1;
      w_off  = 7'(r_ang - 9'd90);
    end
  end

  always_comb begin
    w_sin_idx = w_off;
    w_cos_idx = 7'(QTR) - w_off;
    w_sin_neg = 1'b0;
    w_cos_neg = 1'b0;
    unique case (w_quad)
      QUAD_0: ;
      QUAD_1: begin
        w_sin_idx = 7'(QTR) - w_off;
        w_cos_idx = w_off;
        w_cos_neg = 1'b1;
      end
      QUAD_2: begin
        w_sin_neg = 1'b1;
        w_cos_neg = 1'b1;
      end
      QUAD_3: begin
        w_sin_idx = 7'(QTR) - w_off;
        w_cos_idx = w_off;
        w_sin_neg = 1'b1;
      end
    endcase
  end

  sin_quarter_lut u_sin_lut (.i_idx(w_sin_idx), .o_val(w_sin_mag));
  sin_quarter_lut u_cos_lut (.i_idx(w_cos_idx), .o_val(w_cos_mag));

  // Two's-complement negate of a zero magnitude is zero, so no negative zero can appear.
  always_comb begin
    w_sin_ext = {{(ANG_W - 11){1'b0}}, w_sin_mag};
    w_cos_ext = {{(ANG_W - 11){1'b0}}, w_cos_mag};
    w_sin_res = w_sin_neg ? -w_sin_ext : w_sin_ext;
    w_cos_res = w_cos_neg ? -w_cos_ext : w_cos_ext;
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      r_ang <= '0;
      r_cos <= ANG_W'(AMP);
      r_sin <= '0;
    end else begin
      r_ang <= deg_mod360(io_bus.i_theta);
      r_cos <= w_cos_res;
      r_sin <= w_sin_res;
    end
  end

  assign io_bus.o_cos = r_cos;
  assign io_bus.o_sin = r_sin;

endmodule

// File: tb/tb_trig_deg_lut.sv
// Bench for trig_deg_lut: directed angles, sweeps and random angles checked
// against a floating-point trig reference through a 2-deep expectation queue.
module tb_trig_deg_lut;

  typedef struct {
    int    c;
    int    s;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  trig_deg_lut_if bus ();

  trig_deg_lut dut (
    .i_clock (clk),
    .i_RESET (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int rnd_away(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5 + 1.0e-6);
    return -$rtoi(-x + 0.5 + 1.0e-6);
  endfunction

  function automatic exp_t model(input logic signed [31:0] th, input string tag);
    longint a;
    real    rad;
    exp_t   e;
    a     = ((longint'(th) % 360) + 360) % 360;
    rad   = real'(a) * 3.14159265358979323846 / 180.0;
    e.c   = rnd_away(1000.0 * $cos(rad));
    e.s   = rnd_away(1000.0 * $sin(rad));
    e.tag = tag;
    return e;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_mag(input string tag);
    longint ss;
    ss = longint'(bus.o_cos) * longint'(bus.o_cos) + longint'(bus.o_sin) * longint'(bus.o_sin);
    checks++;
    assert ((ss >= 64'sd998000 && ss <= 64'sd1002000) === 1'b1) else begin
      errors++;
      $error("FAIL %s_mag observed=%0d expected=998000..1002000", tag, ss);
    end
  endtask

  task automatic step(input logic signed [31:0] th, input exp_t e);
    exp_t f;
    @(negedge clk);
    f = q.pop_front();
    check({f.tag, "_cos"}, bus.o_cos, f.c);
    check({f.tag, "_sin"}, bus.o_sin, f.s);
    check_mag(f.tag);
    q.push_back(e);
    bus.i_theta = th;
  endtask

  logic signed [31:0] dth [11] = '{32'sd0, 32'sd90, 32'sd180, 32'sd270, 32'sd30, -32'sd30,
                                   32'sd405, 32'sd135, 32'sh80000000, 32'sh7fffffff, 32'sd359};
  int dcos [11] = '{1000, 0, -1000, 0, 866, 866, 707, -707, -616, -602, 1000};
  int dsin [11] = '{0, 1000, 0, -1000, 500, -500, 707, 707, -788, 799, -17};

  initial begin
    exp_t e;
    logic signed [31:0] th;

    rst_n       = 1'b1;
    bus.i_theta = 32'sd77;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_cos", bus.o_cos, 1000);
    check("rst_async_sin", bus.o_sin, 0);
    repeat (2) @(negedge clk);
    check("rst_hold_cos", bus.o_cos, 1000);
    check("rst_hold_sin", bus.o_sin, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rel77_cos", bus.o_cos, 225);
    check("rel77_sin", bus.o_sin, 974);

    q.push_back('{225, 974, "hold77a"});
    q.push_back('{225, 974, "hold77b"});

    for (int i = 0; i < 11; i++) begin
      e.c   = dcos[i];
      e.s   = dsin[i];
      e.tag = $sformatf("dir%0d", dth[i]);
      step(dth[i], e);
    end

    for (int a = 0; a < 720; a++) begin
      th = 32'(a);
      step(th, model(th, $sformatf("up%0d", a)));
    end
    for (int a = -720; a < 0; a++) begin
      th = 32'(a);
      step(th, model(th, $sformatf("neg%0d", a)));
    end

    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_cos", bus.o_cos, 1000);
        check("midrst_sin", bus.o_sin, 0);
        @(negedge clk);
        check("midrst_hold_cos", bus.o_cos, 1000);
        check("midrst_hold_sin", bus.o_sin, 0);
        rst_n = 1'b1;
        q.push_back('{1000, 0, "post_rst0"});
        q.push_back(model(bus.i_theta, "post_rst1"));
      end
      if (i % 2 == 0) th = $urandom();
      else            th = 32'($urandom_range(1440, 0)) - 32'sd720;
      step(th, model(th, $sformatf("rnd%0d_%0d", i, th)));
    end

    step(32'sd0, model(32'sd0, "drain0"));
    step(32'sd0, model(32'sd0, "drain1"));
    step(32'sd0, model(32'sd0, "drain2"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
